// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo write arbiter: FSM encoding and index-width helper.
package fifo_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    // Bits needed to index n items (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating priority encoder: first asserted request found scanning ptr, ptr+1, ... modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               any_o,
    output logic [IW-1:0]      idx_o
);

    int unsigned   cand;
    logic [IW-1:0] cand_idx;

    // Walk the requests in rotated order; the first hit wins.
    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o = 1'b1;
                idx_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-based arbiter sharing one fifo write port between NUM_REQ producers.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned IW        = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_write_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
    output logic                          grant_valid_o,
    output logic [IW-1:0]                 grant_id_o
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    logic                  state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         grant_id_q, grant_id_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;

    logic                  pick_any;
    logic [IW-1:0]         pick_idx;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;
    logic                  last_beat;
    logic [IW-1:0]         next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Select the granted producer's valid and data without indexing past NUM_REQ-1.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IW'(i)) begin
                sel_valid = req_valid_i[i];
                sel_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer      = (state_q == ST_BURST) && sel_valid && !fifo_full_i;
    assign last_beat = (beat_cnt_q == CW'(MAX_BURST - 1));
    assign next_ptr  = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + IW'(1);

    // State and arbitration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next state: grant in IDLE, count beats and rotate on burst end or valid drop.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                state_d    = ST_BURST;
                grant_id_d = pick_idx;
                beat_cnt_d = '0;
            end
        end else begin
            if (xfer) begin
                beat_cnt_d = beat_cnt_q + CW'(1);
            end
            if (!sel_valid || (xfer && last_beat)) begin
                state_d  = ST_IDLE;
                rr_ptr_d = next_ptr;
            end
        end
    end

    // Outputs: beats pass straight through to the fifo while bursting.
    always_comb begin
        req_ready_o     = '0;
        fifo_write_en_o = 1'b0;
        fifo_data_in_o  = '0;
        grant_valid_o   = 1'b0;
        if (state_q == ST_BURST) begin
            grant_valid_o   = 1'b1;
            fifo_write_en_o = xfer;
            fifo_data_in_o  = sel_data;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                req_ready_o[i] = (grant_id_q == IW'(i)) && !fifo_full_i;
            end
        end
    end

    assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a write scoreboard checked by an independent monitor.
module tb_fifo_write_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned MB = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_write_en;
    logic [DW-1:0]    fifo_data_in;
    logic             grant_valid;
    logic [1:0]       grant_id;

    logic [7:0] src_mem [NR][32];
    int         src_hd  [NR] = '{default: 0};
    int         src_tl  [NR] = '{default: 0};
    exp_t       exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    fifo_write_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .fifo_full_i     (fifo_full),
        .fifo_write_en_o (fifo_write_en),
        .fifo_data_in_o  (fifo_data_in),
        .grant_valid_o   (grant_valid),
        .grant_id_o      (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each producer presents the head of its beat list while the list is non-empty.
    for (genvar g = 0; g < NR; g++) begin : g_src
        assign req_valid[g]          = (src_hd[g] < src_tl[g]);
        assign req_data[g*DW +: DW]  = src_mem[g][src_hd[g][4:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic load(input logic [1:0] src, input logic [7:0] d);
        src_mem[src][src_tl[src][4:0]] = d;
        src_tl[src]++;
    endtask

    task automatic expect_beat(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = !grant_valid && (req_valid == '0);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: timeout, sources still busy 0x%0h", req_valid);
        end
    endtask

    task automatic wait_writes(input int n, input string name);
        int cnt;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < n; c++) begin
            @(negedge clk);
            if (fifo_write_en) cnt++;
        end
        if (cnt < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: saw %0d writes, expected %0d", name, cnt, n);
        end
    endtask

    // Handshake sampled mid-cycle; accepted beats are retired just after the edge.
    initial begin : driver
        logic [NR-1:0] fire;
        forever begin
            @(negedge clk);
            fire = rst_n ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i]) src_hd[i]++;
            end
        end
    end

    // Every fifo write must match the next expected beat.
    initial begin : monitor
        exp_t       e;
        logic [3:0] onehot;
        forever begin
            @(negedge clk);
            if (rst_n && fifo_write_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got data 0x%0h id %0d, expected no write",
                             fifo_data_in, grant_id);
                end else begin
                    e      = exp_q.pop_front();
                    onehot = 4'b0001 << e.id;
                    check("wr_id",    32'(grant_id),     32'(e.id));
                    check("wr_data",  32'(fifo_data_in), 32'(e.data));
                    check("wr_ready", 32'(req_ready),    32'(onehot));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [14:0] pat;
        rst_n     = 1'b0;
        fifo_full = 1'b0;

        // Reset with every producer requesting; then four rotated bursts and a wrap back to src0.
        for (int i = 0; i < 8; i++) load(2'd0, 8'(i));
        for (int s = 1; s < 4; s++) begin
            for (int i = 0; i < 4; i++) load(2'(s), 8'(s * 16 + i));
        end
        for (int i = 0; i < 4; i++) expect_beat(2'd0, 8'(i));
        for (int s = 1; s < 4; s++) begin
            for (int i = 0; i < 4; i++) expect_beat(2'(s), 8'(s * 16 + i));
        end
        for (int i = 4; i < 8; i++) expect_beat(2'd0, 8'(i));
        repeat (2) @(negedge clk);
        check("t1_rst_grant_valid", 32'(grant_valid),   32'd0);
        check("t1_rst_req_ready",   32'(req_ready),     32'd0);
        check("t1_rst_write_en",    32'(fifo_write_en), 32'd0);
        check("t1_rst_data",        32'(fifo_data_in),  32'd0);
        check("t1_rst_grant_id",    32'(grant_id),      32'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_idle_cycle", 32'(grant_valid), 32'd0);
        @(negedge clk);
        check("t1_first_grant_valid", 32'(grant_valid), 32'd1);
        check("t1_first_grant_id",    32'(grant_id),    32'd0);
        wait_idle();

        // Lone streaming source: 4 writes, 1 arbitration gap, repeated.
        sync();
        for (int i = 0; i < 10; i++) begin
            load(2'd2, 8'(8'hA0 + i));
            expect_beat(2'd2, 8'(8'hA0 + i));
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            pat[14-i] = fifo_write_en;
        end
        check("t2_write_pattern", 32'(pat), 32'(15'b011110111101100));
        wait_idle();

        // Backpressure after beat 2 stalls the burst for 3 cycles.
        sync();
        for (int i = 0; i < 6; i++) begin
            load(2'd0, 8'(8'hC0 + i));
            expect_beat(2'd0, 8'(8'hC0 + i));
        end
        wait_writes(2, "t4_first_two");
        sync();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_write_en", 32'(fifo_write_en), 32'd0);
            check("t4_stall_ready",    32'(req_ready),     32'd0);
            check("t4_stall_grant",    32'(grant_valid),   32'd1);
        end
        sync();
        fifo_full = 1'b0;
        @(negedge clk);
        check("t4_beat3", 32'(fifo_write_en), 32'd1);
        @(negedge clk);
        check("t4_beat4", 32'(fifo_write_en), 32'd1);
        @(negedge clk);
        check("t4_end_at_4", 32'(grant_valid), 32'd0);
        wait_idle();

        // src1 stops after 2 beats; the waiting src3 gets the next grant.
        sync();
        load(2'd1, 8'hD0);
        load(2'd1, 8'hD1);
        load(2'd3, 8'hE0);
        load(2'd3, 8'hE1);
        expect_beat(2'd1, 8'hD0);
        expect_beat(2'd1, 8'hD1);
        expect_beat(2'd3, 8'hE0);
        expect_beat(2'd3, 8'hE1);
        wait_writes(2, "t5_src1_writes");
        @(negedge clk);
        check("t5_drop_no_write", 32'(fifo_write_en), 32'd0);
        @(negedge clk);
        check("t5_idle", 32'(grant_valid), 32'd0);
        @(negedge clk);
        check("t5_grant_valid", 32'(grant_valid), 32'd1);
        check("t5_grant_id",    32'(grant_id),    32'd3);
        wait_idle();

        // Move the pointer off zero, then reset during beat 3 of a src1 burst.
        sync();
        load(2'd2, 8'hB0);
        expect_beat(2'd2, 8'hB0);
        wait_idle();
        sync();
        for (int i = 0; i < 6; i++) load(2'd1, 8'(8'hF0 + i));
        expect_beat(2'd1, 8'hF0);
        expect_beat(2'd1, 8'hF1);
        wait_writes(2, "t6_first_two");
        sync();
        check("t6_beat3_present", 32'(fifo_write_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_write_en",    32'(fifo_write_en), 32'd0);
        check("t6_rst_req_ready",   32'(req_ready),     32'd0);
        check("t6_rst_grant_valid", 32'(grant_valid),   32'd0);
        repeat (2) @(negedge clk);
        load(2'd0, 8'h60);
        load(2'd0, 8'h61);
        load(2'd3, 8'h70);
        expect_beat(2'd0, 8'h60);
        expect_beat(2'd0, 8'h61);
        for (int i = 2; i < 6; i++) expect_beat(2'd1, 8'(8'hF0 + i));
        expect_beat(2'd3, 8'h70);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_idle_after_rst", 32'(grant_valid), 32'd0);
        @(negedge clk);
        check("t6_regrant_valid", 32'(grant_valid), 32'd1);
        check("t6_regrant_id",    32'(grant_id),    32'd0);
        wait_idle();

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
